// File: rtl/dmem_ctrl_pkg.sv
// dmem_ctrl_pkg: shared FSM state type, wait-state counter sizing and parity helper for dmem_ctrl.
package dmem_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, DONE} dmem_state_t;
  localparam int MAX_WAIT = 15;
  localparam int CNT_W = $clog2(MAX_WAIT + 1);
  function automatic logic even_par(input logic [63:0] d);
    return ^d;
  endfunction
endpackage

// File: rtl/dmem_ctrl_if.sv
// dmem_ctrl_if: multi-channel dmem request/response bundle; Data_perr exists only with DMEM_CTRL_PARITY_EN.
interface dmem_ctrl_if #(
  parameter int NUM_CH = 2,
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
);
  logic [NUM_CH-1:0] Data_req;
  logic [NUM_CH-1:0] Data_rd;
  logic [NUM_CH*ADDR_W-1:0] Data_addr;
  logic [NUM_CH*DATA_W-1:0] Data_din;
  logic [NUM_CH*DATA_W-1:0] Data_dout;
  logic [NUM_CH-1:0] complete_data;
  logic busy;
`ifdef DMEM_CTRL_PARITY_EN
  logic [NUM_CH-1:0] Data_perr;
`endif
  modport master(
    output Data_req, Data_rd, Data_addr, Data_din,
    input Data_dout, complete_data, busy
`ifdef DMEM_CTRL_PARITY_EN
    , Data_perr
`endif
  );
  modport slave(
    input Data_req, Data_rd, Data_addr, Data_din,
    output Data_dout, complete_data, busy
`ifdef DMEM_CTRL_PARITY_EN
    , Data_perr
`endif
  );
endinterface

// File: rtl/dmem_ctrl_rr_arb.sv
// dmem_rr_arb: combinational round-robin grant, searching from the channel after last.
module dmem_rr_arb #(
  parameter int NUM_CH = 2,
  localparam int IW = NUM_CH > 1 ? $clog2(NUM_CH) : 1
) (
  input logic [NUM_CH-1:0] req,
  input logic [IW-1:0] last,
  output logic [NUM_CH-1:0] gnt,
  output logic [IW-1:0] idx
);
  always_comb begin
    idx = last;
    for (int i = NUM_CH; i >= 1; i--)
      if (req[(int'(last) + i) % NUM_CH]) idx = IW'((int'(last) + i) % NUM_CH);
    gnt = |req ? NUM_CH'(1) << idx : '0;
  end
endmodule

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: round-robin multi-channel data-memory responder with programmable wait states.
// Define DMEM_CTRL_PARITY_EN to store an even-parity bit per word and report Data_perr on reads.
module dmem_ctrl import dmem_ctrl_pkg::*; #(
  parameter int NUM_CH = 2,
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int DEPTH = 1024,
  parameter int WAIT_CYC = 1
) (
  input logic clock,
  input logic reset,
  dmem_ctrl_if.slave bus
);
  localparam int IW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int WC = WAIT_CYC > MAX_WAIT ? MAX_WAIT : WAIT_CYC;
`ifdef DMEM_CTRL_PARITY_EN
  localparam int MW = DATA_W + 1;
`else
  localparam int MW = DATA_W;
`endif
  dmem_state_t state, nxt;
  logic [CNT_W-1:0] cnt;
  logic [IW-1:0] last, gidx, arb_idx;
  logic [NUM_CH-1:0] arb_gnt;
  logic rd, in_range;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] din;
  logic [MW-1:0] word;
  logic [MW-1:0] mem [DEPTH];
  dmem_rr_arb #(.NUM_CH(NUM_CH)) u_arb (.req(bus.Data_req), .last(last), .gnt(arb_gnt), .idx(arb_idx));
  // extra bit keeps the compare correct when DEPTH == 2**ADDR_W
  assign in_range = {1'b0, addr} < (ADDR_W + 1)'(DEPTH);
  assign word = mem[addr[AW-1:0]];
  assign bus.busy = state != IDLE;
  always_comb begin
    nxt = IDLE;
    if (state == IDLE) nxt = |arb_gnt ? (WC == 0 ? DONE : WAIT) : IDLE;
    else if (state == WAIT) nxt = cnt == CNT_W'(1) ? DONE : WAIT;
  end
  always_ff @(posedge clock or negedge reset)
    if (!reset) state <= IDLE;
    else state <= nxt;
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      cnt <= '0;
      last <= IW'(NUM_CH - 1);
      gidx <= '0;
      rd <= 1'b0;
      addr <= '0;
      din <= '0;
      bus.Data_dout <= '0;
      bus.complete_data <= '0;
`ifdef DMEM_CTRL_PARITY_EN
      bus.Data_perr <= '0;
`endif
    end else begin
      bus.complete_data <= '0;
`ifdef DMEM_CTRL_PARITY_EN
      bus.Data_perr <= '0;
`endif
      if (state == IDLE && |arb_gnt) begin
        gidx <= arb_idx;
        rd <= bus.Data_rd[arb_idx];
        addr <= bus.Data_addr[arb_idx*ADDR_W +: ADDR_W];
        din <= bus.Data_din[arb_idx*DATA_W +: DATA_W];
        cnt <= CNT_W'(WC);
      end
      if (state == WAIT) cnt <= cnt - 1'b1;
      if (state == DONE) begin
        bus.complete_data[gidx] <= 1'b1;
        last <= gidx;
        if (rd) bus.Data_dout[gidx*DATA_W +: DATA_W] <= in_range ? word[DATA_W-1:0] : '0;
`ifdef DMEM_CTRL_PARITY_EN
        bus.Data_perr[gidx] <= rd && in_range && even_par(64'(word));
`endif
      end
    end
  // storage is not reset; writes only commit from DONE, so a reset mid-access drops them
  always_ff @(posedge clock)
`ifdef DMEM_CTRL_PARITY_EN
    if (state == DONE && !rd && in_range) mem[addr[AW-1:0]] <= {even_par(64'(din)), din};
`else
    if (state == DONE && !rd && in_range) mem[addr[AW-1:0]] <= din;
`endif
endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: directed and randomized checks of dmem_ctrl against a transaction-level model.
// Parity checks are included when DMEM_CTRL_PARITY_EN is defined.
module tb_dmem_ctrl;
  localparam int NC = 2, DW = 16, AW = 16, DEP = 1024, WC = 1;
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;
  dmem_ctrl_if #(.NUM_CH(NC), .DATA_W(DW), .ADDR_W(AW)) b1 ();
  dmem_ctrl_if #(.NUM_CH(NC), .DATA_W(DW), .ADDR_W(AW)) b0 ();
  dmem_ctrl #(.NUM_CH(NC), .DATA_W(DW), .ADDR_W(AW), .DEPTH(DEP), .WAIT_CYC(WC)) u1 (
    .clock(clock), .reset(reset), .bus(b1));
  dmem_ctrl #(.NUM_CH(NC), .DATA_W(DW), .ADDR_W(AW), .DEPTH(DEP), .WAIT_CYC(0)) u0 (
    .clock(clock), .reset(reset), .bus(b0));

  int n_cmp = 0, n_err = 0;
  logic [DW-1:0] mm [int];
  int wq[$];
  logic [DW-1:0] expd [NC];
  int rr;
  int flip_addr = -1;
  logic [NC-1:0] rm, rrd;
  logic [NC*AW-1:0] ra;
  logic [NC*DW-1:0] rdin;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [NC*DW-1:0] dvec();
    logic [NC*DW-1:0] v;
    for (int i = 0; i < NC; i++) v[i*DW +: DW] = expd[i];
    return v;
  endfunction

  // issue one request per channel in m, then check every completion in round-robin order
  task automatic batch(input logic [NC-1:0] m, input logic [NC-1:0] r,
                       input logic [NC*AW-1:0] a, input logic [NC*DW-1:0] d);
    logic [NC-1:0] pend;
    int c, n, ad;
    pend = m;
    b1.Data_rd = r;
    b1.Data_addr = a;
    b1.Data_din = d;
    b1.Data_req = m;
    while (pend != 0) begin
      c = 0;
      for (int i = 1; i <= NC; i++) begin
        int k;
        k = (rr + i) % NC;
        if (pend[k]) begin
          c = k;
          break;
        end
      end
      n = 0;
      do begin
        @(posedge clock); #1;
        n++;
        if (n == 1) chk("busy", 64'(b1.busy), 1);
      end while (b1.complete_data == 0 && n < 4 * (WC + 2));
      chk("latency", n, WC + 2);
      chk("grant", 64'(b1.complete_data), 1 << c);
      ad = int'(a[c*AW +: AW]);
      if (r[c]) expd[c] = ad < DEP ? mm[ad] : '0;
      else if (ad < DEP) begin
        mm[ad] = d[c*DW +: DW];
        wq.push_back(ad);
      end
      chk("dout", 64'(b1.Data_dout), 64'(dvec()));
`ifdef DMEM_CTRL_PARITY_EN
      chk("perr", 64'(b1.Data_perr), (r[c] && ad == flip_addr) ? 1 << c : 0);
`endif
      rr = c;
      pend[c] = 1'b0;
      b1.Data_req[c] = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    {b1.Data_req, b1.Data_rd, b1.Data_addr, b1.Data_din} = '0;
    {b0.Data_req, b0.Data_rd, b0.Data_addr, b0.Data_din} = '0;
    reset = 1'b0;
    #1;
    chk("rst_busy", 64'(b1.busy), 0);
    chk("rst_cmpl", 64'(b1.complete_data), 0);
    chk("rst_dout", 64'(b1.Data_dout), 0);
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    rr = NC - 1;
    for (int i = 0; i < NC; i++) expd[i] = '0;

    batch(2'b01, 2'b00, {16'h0, 16'h0010}, {16'h0, 16'h1234});
    batch(2'b01, 2'b01, {16'h0, 16'h0010}, '0);
    chk("rd_1234", 64'(b1.Data_dout[15:0]), 64'h1234);
    batch(2'b11, 2'b00, {16'h0030, 16'h0020}, {16'h0303, 16'h5A5A});
    batch(2'b11, 2'b11, {16'h0020, 16'h0030}, '0);
    batch(2'b01, 2'b00, {16'h0, 16'h0000}, {16'h0, 16'hCAFE});
    batch(2'b01, 2'b01, {16'h0, 16'h0400}, '0);
    chk("oob_rd", 64'(b1.Data_dout[15:0]), 0);
    batch(2'b10, 2'b00, {16'h0400, 16'h0}, {16'hDEAD, 16'h0});
    batch(2'b01, 2'b01, {16'h0, 16'h0000}, '0);
    chk("oob_wr_alias", 64'(b1.Data_dout[15:0]), 64'hCAFE);

    b1.Data_req = 2'b01;
    b1.Data_rd = 2'b00;
    b1.Data_addr = {16'h0, 16'h0020};
    b1.Data_din = {16'h0, 16'hBEEF};
    @(posedge clock); #1;
    chk("pre_rst_busy", 64'(b1.busy), 1);
    reset = 1'b0;
    #1;
    chk("mid_rst_busy", 64'(b1.busy), 0);
    chk("mid_rst_cmpl", 64'(b1.complete_data), 0);
    chk("mid_rst_dout", 64'(b1.Data_dout), 0);
    b1.Data_req = '0;
    @(posedge clock); #1;
    reset = 1'b1;
    rr = NC - 1;
    for (int i = 0; i < NC; i++) expd[i] = '0;
    batch(2'b11, 2'b11, {16'h0030, 16'h0020}, '0);
    batch(2'b01, 2'b01, {16'h0, 16'h0010}, '0);
    batch(2'b11, 2'b11, {16'h0020, 16'h0010}, '0);

    repeat (30) begin
      rm = NC'($urandom_range(1, 3));
      for (int c = 0; c < NC; c++) begin
        rrd[c] = $urandom_range(0, 1) == 1;
        if ($urandom_range(0, 7) == 0) ra[c*AW +: AW] = AW'(DEP + $urandom_range(0, 100));
        else if (rrd[c]) ra[c*AW +: AW] = AW'(wq[$urandom_range(0, wq.size() - 1)]);
        else ra[c*AW +: AW] = AW'($urandom_range(0, DEP - 1));
        rdin[c*DW +: DW] = DW'($urandom);
      end
      batch(rm, rrd, ra, rdin);
    end

`ifdef DMEM_CTRL_PARITY_EN
    flip_addr = 16;
    u1.mem[16] <= u1.mem[16] ^ 'h1;
    #1;
    mm[16] = mm[16] ^ 16'h1;
    batch(2'b01, 2'b01, {16'h0, 16'h0010}, '0);
    flip_addr = -1;
    batch(2'b01, 2'b01, {16'h0, 16'h0020}, '0);
`endif

    b0.Data_req = 2'b10;
    b0.Data_rd = 2'b00;
    b0.Data_addr = {16'h0005, 16'h0};
    b0.Data_din = {16'hABCD, 16'h0};
    n = 0;
    do begin
      @(posedge clock); #1;
      n++;
    end while (b0.complete_data == 0 && n < 8);
    chk("u0_wr_lat", n, 2);
    chk("u0_wr_cmpl", 64'(b0.complete_data), 2);
    b0.Data_rd = 2'b10;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clock); #1;
      chk("u0_pulse", 64'(b0.complete_data), (k % 2 == 0) ? 2 : 0);
      if (k % 2 == 0) chk("u0_dout", 64'(b0.Data_dout), 64'({16'hABCD, 16'h0000}));
    end
    b0.Data_req = '0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
